unicycle_data_mem: RTL and testbench

Single-port synchronous memory slave on the multicycle core's memory interface (`instType`, `dataAddress`, `writeData`, `readData`). It serves both instruction fetches and data accesses.
- Loads: byte-lane extraction with sign/zero extension, one-cycle registered read latency.
- Stores: byte/halfword/word writes with lane masking.
- `tohost` register: test-termination mailbox for the riscv-tests flow.

---
 rtl/unicycle_data_mem.sv | 158 +++++++++++++++
 tb/tb_unicycle_data_mem.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/unicycle_data_mem.sv
// unicycle_data_mem: single-port synchronous RAM slave for the multicycle core.
// Byte-lane loads/stores, one-cycle read latency, tohost mailbox.
package unicycle_mem_pkg;
  typedef enum logic [3:0] {
    MEM_NOP = 4'h0,
    MEM_SB  = 4'h1,
    MEM_SH  = 4'h2,
    MEM_SW  = 4'h3,
    MEM_LB  = 4'h8,
    MEM_LH  = 4'h9,
    MEM_LW  = 4'hA,
    MEM_LBU = 4'hC,
    MEM_LHU = 4'hD
  } mem_inst_type_t;
endpackage

module unicycle_data_mem
  import unicycle_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
  parameter string       INIT_FILE   = ""
) (
  input  logic           clk,
  input  logic           rst,
  input  mem_inst_type_t instType_i,
  input  logic [31:0]    dataAddress_i,
  input  logic [31:0]    writeData_i,
  output logic [31:0]    readData_o,
  output logic           busErr_o,
  output logic           tohost_valid_o,
  output logic [31:0]    tohost_data_o
);

  localparam int AW = $clog2(4 * DEPTH_WORDS);
  localparam int IW = AW - 2;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] off;
  logic [IW-1:0] idx;
  logic hit_tohost, hit_ram;
  logic is_load, is_store, is_nop;
  logic mis;
  logic [3:0] be;
  logic [31:0] wdata;
  logic ram_we, th_we, err;

  assign off        = dataAddress_i - BASE_ADDR;
  assign idx        = off[AW-1:2];
  assign hit_tohost = dataAddress_i[31:2] == TOHOST_ADDR[31:2];
  assign hit_ram    = (off < RAM_BYTES) && !hit_tohost;
  assign is_nop     = instType_i == MEM_NOP;
  assign is_load    = instType_i[3];
  assign is_store   = !instType_i[3] && !is_nop;

  // Alignment check, lane enables and replicated write data.
  always_comb begin
    mis   = 1'b0;
    be    = 4'b0000;
    wdata = writeData_i;
    case (instType_i)
      MEM_SB: begin
        be    = 4'b0001 << dataAddress_i[1:0];
        wdata = {4{writeData_i[7:0]}};
      end
      MEM_SH: begin
        mis   = dataAddress_i[0];
        be    = 4'b0011 << dataAddress_i[1:0];
        wdata = {2{writeData_i[15:0]}};
      end
      MEM_SW: begin
        mis = dataAddress_i[1:0] != 2'b00;
        be  = 4'b1111;
      end
      MEM_LH, MEM_LHU: mis = dataAddress_i[0];
      MEM_LW:          mis = dataAddress_i[1:0] != 2'b00;
      default:         mis = 1'b0;
    endcase
  end

  assign ram_we = is_store && hit_ram && !mis && !rst;
  assign th_we  = is_store && hit_tohost && !mis && !rst;
  assign err    = !is_nop && (!(hit_ram || hit_tohost) || mis);

  // RAM byte-lane writes; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  logic [31:0]    rd_word;
  mem_inst_type_t rd_type;
  logic [1:0]     rd_lane;
  logic           rd_ok;

  // Read-first capture of the addressed word plus load context.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word <= '0;
      rd_type <= MEM_NOP;
      rd_lane <= 2'b00;
      rd_ok   <= 1'b0;
    end else begin
      rd_word <= hit_tohost ? tohost_data_o : ram[idx];
      rd_type <= instType_i;
      rd_lane <= dataAddress_i[1:0];
      rd_ok   <= is_load && (hit_ram || hit_tohost) && !mis;
    end
  end

  // Bus error pulse and sticky tohost mailbox.
  always_ff @(posedge clk) begin
    if (rst) begin
      busErr_o       <= 1'b0;
      tohost_valid_o <= 1'b0;
      tohost_data_o  <= '0;
    end else begin
      busErr_o <= err;
      if (th_we) begin
        tohost_valid_o <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (be[i]) tohost_data_o[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Lane extraction and sign/zero extension of the registered word.
  always_comb begin
    readData_o = '0;
    rd_byte    = 8'h00;
    case (rd_lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
    if (rd_ok) begin
      case (rd_type)
        MEM_LW:  readData_o = rd_word;
        MEM_LB:  readData_o = {{24{rd_byte[7]}}, rd_byte};
        MEM_LBU: readData_o = {24'h0, rd_byte};
        MEM_LH:  readData_o = {{16{rd_half[15]}}, rd_half};
        MEM_LHU: readData_o = {16'h0, rd_half};
        default: readData_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_unicycle_data_mem.sv
// tb_unicycle_data_mem: directed vectors, scoreboard queue
// and a negedge monitor checking readData/busErr/tohost.
module tb_unicycle_data_mem;
  import unicycle_mem_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  mem_inst_type_t inst = MEM_NOP;
  logic [31:0]    addr = '0;
  logic [31:0]    wd = '0;
  logic [31:0]    rdata;
  logic           berr;
  logic           thv;
  logic [31:0]    thd;

  unicycle_data_mem dut (
    .clk           (clk),
    .rst           (rst),
    .instType_i    (inst),
    .dataAddress_i (addr),
    .writeData_i   (wd),
    .readData_o    (rdata),
    .busErr_o      (berr),
    .tohost_valid_o(thv),
    .tohost_data_o (thd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        thv;
    logic [31:0] thd;
    int          due;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  logic        exp_thv = 1'b0;
  logic [31:0] exp_thd = '0;

  always @(posedge clk) cyc++;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e_mon = q.pop_front();
      chk({e_mon.name, ".rd"}, rdata, e_mon.rd);
      chk({e_mon.name, ".err"}, {31'h0, berr}, {31'h0, e_mon.err});
      chk({e_mon.name, ".thv"}, {31'h0, thv}, {31'h0, e_mon.thv});
      chk({e_mon.name, ".thd"}, thd, e_mon.thd);
    end
  end

  task automatic req(input string n, input logic r, input mem_inst_type_t t,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] xrd, input logic xerr);
    exp_t x;
    @(posedge clk);
    #1;
    rst  = r;
    inst = t;
    addr = a;
    wd   = d;
    x.rd   = xrd;
    x.err  = xerr;
    x.thv  = exp_thv;
    x.thd  = exp_thd;
    x.due  = cyc + 1;
    x.name = n;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    req("rst0", 1, MEM_NOP, 32'h0, 32'h0, 32'h0, 0);
    req("rst1", 1, MEM_LW, 32'h8000_0000, 32'h0, 32'h0, 0);
    req("pre0", 0, MEM_SW, 32'h8000_0000, 32'h8765_F0A1, 32'h0, 0);
    req("pre1", 0, MEM_SW, 32'h8000_0000, 32'h8765_F0A1, 32'h0, 0);
    req("lw0",  0, MEM_LW,  32'h8000_0000, 32'h0, 32'h8765_F0A1, 0);
    req("lb0",  0, MEM_LB,  32'h8000_0000, 32'h0, 32'hFFFF_FFA1, 0);
    req("lbu1", 0, MEM_LBU, 32'h8000_0001, 32'h0, 32'h0000_00F0, 0);
    req("lh2",  0, MEM_LH,  32'h8000_0002, 32'h0, 32'hFFFF_8765, 0);
    req("lhu2", 0, MEM_LHU, 32'h8000_0002, 32'h0, 32'h0000_8765, 0);
    req("lb3",  0, MEM_LB,  32'h8000_0003, 32'h0, 32'hFFFF_FF87, 0);
    req("lhu0", 0, MEM_LHU, 32'h8000_0000, 32'h0, 32'h0000_F0A1, 0);
    req("sw4a", 0, MEM_SW, 32'h8000_0004, 32'h0, 32'h0, 0);
    req("sw4b", 0, MEM_SW, 32'h8000_0004, 32'h0, 32'h0, 0);
    req("sb6a", 0, MEM_SB, 32'h8000_0006, 32'hFFFF_FFAB, 32'h0, 0);
    req("sb6b", 0, MEM_SB, 32'h8000_0006, 32'hFFFF_FFAB, 32'h0, 0);
    req("sh4a", 0, MEM_SH, 32'h8000_0004, 32'hFFFF_1234, 32'h0, 0);
    req("sh4b", 0, MEM_SH, 32'h8000_0004, 32'hFFFF_1234, 32'h0, 0);
    req("lw4",  0, MEM_LW, 32'h8000_0004, 32'h0, 32'h00AB_1234, 0);
    req("sh5",  0, MEM_SH, 32'h8000_0005, 32'h0000_FFFF, 32'h0, 1);
    req("lw4b", 0, MEM_LW, 32'h8000_0004, 32'h0, 32'h00AB_1234, 0);
    req("lwm2", 0, MEM_LW, 32'h8000_0002, 32'h0, 32'h0, 1);
    req("nop",  0, MEM_NOP, 32'h8000_0002, 32'h0, 32'h0, 0);
    req("lwlo", 0, MEM_LW, 32'h7FFF_FFFC, 32'h0, 32'h0, 1);
    req("lwhi", 0, MEM_LW, 32'h8001_0000, 32'h0, 32'h0, 1);
    req("swla", 0, MEM_SW, 32'h8000_FFFC, 32'h55AA_0011, 32'h0, 0);
    req("swlb", 0, MEM_SW, 32'h8000_FFFC, 32'h55AA_0011, 32'h0, 0);
    req("lwl",  0, MEM_LW, 32'h8000_FFFC, 32'h0, 32'h55AA_0011, 0);
    req("lw0b", 0, MEM_LW, 32'h8000_0000, 32'h0, 32'h8765_F0A1, 0);
    exp_thv = 1'b1;
    exp_thd = 32'h0000_0001;
    req("th1a", 0, MEM_SW, 32'h8000_1000, 32'h0000_0001, 32'h0, 0);
    req("th1b", 0, MEM_SW, 32'h8000_1000, 32'h0000_0001, 32'h0, 0);
    exp_thd = 32'h00EE_0001;
    req("thsb", 0, MEM_SB, 32'h8000_1002, 32'h0000_00EE, 32'h0, 0);
    req("thlw", 0, MEM_LW, 32'h8000_1000, 32'h0, 32'h00EE_0001, 0);
    req("lw0c", 0, MEM_LW, 32'h8000_0000, 32'h0, 32'h8765_F0A1, 0);
    exp_thv = 1'b0;
    exp_thd = 32'h0;
    req("rstth", 1, MEM_NOP, 32'h0, 32'h0, 32'h0, 0);
    req("rstsw", 1, MEM_SW, 32'h8000_0000, 32'h1111_1111, 32'h0, 0);
    req("lw0d", 0, MEM_LW, 32'h8000_0000, 32'h0, 32'h8765_F0A1, 0);
    req("rstlw", 1, MEM_LW, 32'h8000_0000, 32'h0, 32'h0, 0);
    req("dba",  0, MEM_SW, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0);
    req("dbb",  0, MEM_SW, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0);
    req("dbl",  0, MEM_LW, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    req("dbl2", 0, MEM_LW, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    req("idle", 0, MEM_NOP, 32'h0, 32'h0, 32'h0, 0);
    repeat (4) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
